// File: rtl/imem_program_loader.sv
// Byte-stream program loader: assembles little-endian words, writes them into instruction
// memory in order and holds the CPU in reset until an all-zero terminator has been stored.
module imem_program_loader #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned MAX_WORDS  = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  rx_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [ADDR_WIDTH:0]   word_count
);

   typedef enum logic [2:0] {StIdle, StRecv, StWrite, StDone, StError} state_e;

   localparam logic [ADDR_WIDTH:0] MaxWords = (ADDR_WIDTH+1)'(MAX_WORDS);

   state_e                state_q, state_d;
   logic [1:0]            idx_q, idx_d;
   logic [23:0]           part_q, part_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  rx_ready_q, imem_we_q, cpu_hold_q, busy_q, done_q, overflow_q;
   logic                  xfer;

   assign xfer = rx_valid && rx_ready_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      part_d  = part_q;
      count_d = count_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         StIdle, StDone, StError: begin
            if (start) begin
               state_d = StRecv;
               idx_d   = 2'd0;
               part_d  = '0;
               count_d = '0;
            end
         end
         StRecv: begin
            if (xfer) begin
               idx_d = idx_q + 2'd1;
               unique case (idx_q)
                  2'd0: part_d[7:0]   = rx_data;
                  2'd1: part_d[15:8]  = rx_data;
                  2'd2: part_d[23:16] = rx_data;
                  2'd3: begin
                     // Last byte goes straight into the write word, bypassing the partial.
                     state_d = StWrite;
                     addr_d  = count_q[ADDR_WIDTH-1:0];
                     wdata_d = {rx_data, part_q};
                  end
               endcase
            end
         end
         StWrite: begin
            count_d = count_q + 1'b1;
            idx_d   = 2'd0;
            if (wdata_q == 32'd0) begin
               state_d = StDone;
            end else if (count_d == MaxWords) begin
               state_d = StError;
            end else begin
               state_d = StRecv;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Status outputs are flopped from the next state so they change on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         idx_q      <= 2'd0;
         part_q     <= '0;
         count_q    <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rx_ready_q <= 1'b0;
         imem_we_q  <= 1'b0;
         cpu_hold_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         part_q     <= part_d;
         count_q    <= count_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rx_ready_q <= (state_d == StRecv);
         imem_we_q  <= (state_d == StWrite);
         cpu_hold_q <= (state_d != StDone);
         busy_q     <= (state_d == StRecv) || (state_d == StWrite);
         done_q     <= (state_d == StDone);
         overflow_q <= (state_d == StError);
      end
   end

   assign rx_ready   = rx_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_hold   = cpu_hold_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign overflow   = overflow_q;
   assign word_count = count_q;

endmodule
